// File: rtl/rv_mem_pkg.sv
// Shared line geometry and fetch FSM state encoding for the instruction-memory responder.
package rv_mem_pkg;
   localparam int LINE_WORDS = 8;
   localparam int WORD_W     = 32;
   localparam int OFFSET_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/imem_word_array.sv
// Word-addressed program store: one write port plus an 8-word line read port.
// The read port forwards a same-cycle write so a load landing on the response edge is seen.
module imem_word_array
   import rv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                                   clk,
   input  logic                                   we,
   input  logic [$clog2(DEPTH_WORDS)-1:0]         waddr,
   input  logic [WORD_W-1:0]                      wdata,
   input  logic [$clog2(DEPTH_WORDS)-OFFSET_W-1:0] line_idx,
   input  logic [OFFSET_W-1:0]                    rot,
   output logic [LINE_WORDS-1:0][WORD_W-1:0]      words
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   for (genvar k = 0; k < LINE_WORDS; k++) begin : g_rd
      logic [OFFSET_W-1:0] off;
      logic [AW-1:0]       idx;
      assign off = rot + OFFSET_W'(k);
      assign idx = {line_idx, off};
      assign words[k] = (we && (waddr == idx)) ? wdata : mem[idx];
   end
endmodule

// File: rtl/imem_line_responder.sv
// Instruction-memory line responder: fixed-latency 8-word line fetch for an I-cache miss.
// Define IMEM_CRIT_WORD_FIRST_EN to return the line rotated so line_0 is the missed word.
//
// state | meaning
// IDLE  | waiting for read_request; only state that accepts a fetch
// WAIT  | latency countdown, counter decrements to 0
// RESP  | read line, register onto line_0..7, pulse data_valid
module imem_line_responder
   import rv_mem_pkg::*;
#(
   parameter int LATENCY     = 4,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_request,
   input  logic [31:0] addr,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        busy,
   output logic        data_valid,
   output logic [31:0] line_0,
   output logic [31:0] line_1,
   output logic [31:0] line_2,
   output logic [31:0] line_3,
   output logic [31:0] line_4,
   output logic [31:0] line_5,
   output logic [31:0] line_6,
   output logic [31:0] line_7
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int LW = AW - OFFSET_W;
   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
`ifdef IMEM_CRIT_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   fetch_state_t                      state;
   logic [3:0]                        cnt;
   logic [LW-1:0]                     req_line;
   logic [OFFSET_W-1:0]               req_off;
   logic [LINE_WORDS-1:0][WORD_W-1:0] rd_words;
   logic [LINE_WORDS-1:0][WORD_W-1:0] line_q;
   logic                              we;
   logic                              unused_bits;

   // reset outranks a preload in the same cycle
   assign we = load_en & ~reset;
   assign unused_bits = ^{addr[31:AW+2], addr[1:0], load_addr[31:AW+2], load_addr[1:0]};

   imem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk      (clk),
      .we       (we),
      .waddr    (load_addr[AW+1:2]),
      .wdata    (load_data),
      .line_idx (req_line),
      .rot      (req_off),
      .words    (rd_words)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         line_q     <= '0;
         req_line   <= '0;
         req_off    <= '0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (read_request) begin
                  req_line <= addr[AW+1:OFFSET_W+2];
                  req_off  <= CWF ? addr[OFFSET_W+1:2] : '0;
                  busy     <= 1'b1;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP: begin
               line_q     <= rd_words;
               data_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign line_0 = line_q[0];
   assign line_1 = line_q[1];
   assign line_2 = line_q[2];
   assign line_3 = line_q[3];
   assign line_4 = line_q[4];
   assign line_5 = line_q[5];
   assign line_6 = line_q[6];
   assign line_7 = line_q[7];
endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: a LATENCY=4 instance and a LATENCY=1 instance
// sharing clock, reset and preload bus.
module tb_imem_line_responder;
   localparam int DEPTH = 1024;
`ifdef IMEM_CRIT_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, rr, rr1, load_en;
   logic [31:0] addr, addr1, load_addr, load_data;
   logic        busy, dv, busy1, dv1;
   logic [31:0] ln  [8];
   logic [31:0] ln1 [8];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   imem_line_responder #(.LATENCY(4), .DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset), .read_request(rr), .addr(addr),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy), .data_valid(dv),
      .line_0(ln[0]), .line_1(ln[1]), .line_2(ln[2]), .line_3(ln[3]),
      .line_4(ln[4]), .line_5(ln[5]), .line_6(ln[6]), .line_7(ln[7])
   );

   imem_line_responder #(.LATENCY(1), .DEPTH_WORDS(DEPTH)) dut1 (
      .clk(clk), .reset(reset), .read_request(rr1), .addr(addr1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy1), .data_valid(dv1),
      .line_0(ln1[0]), .line_1(ln1[1]), .line_2(ln1[2]), .line_3(ln1[3]),
      .line_4(ln1[4]), .line_5(ln1[5]), .line_6(ln1[6]), .line_7(ln1[7])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // drive a one-cycle request on the LATENCY=4 instance, return edges until data_valid
   task automatic fetch0(input logic [31:0] a, output int lat);
      rr   = 1'b1;
      addr = a;
      @(negedge clk);
      rr  = 1'b0;
      lat = 0;
      while (!dv && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, busy_cnt, pulses, pulse_c;
      logic [31:0] pulse_l0;
      reset = 1'b1; rr = 1'b0; rr1 = 1'b0; load_en = 1'b0;
      addr = '0; addr1 = '0; load_addr = '0; load_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_dv", {31'd0, dv}, 32'd0);
      chk("reset_line0", ln[0], 32'd0);
      chk("reset_line7", ln[7], 32'd0);
      reset = 1'b0;

      // preload words 0x40..0x4F with 0xA0..0xAF
      for (int i = 0; i < 16; i++) begin
         load_en   = 1'b1;
         load_addr = 32'h100 + 32'(4 * i);
         load_data = 32'hA0 + 32'(i);
         @(negedge clk);
      end
      load_en = 1'b0;

      // basic fetch: latency 4, busy high 4 samples, aligned line
      rr = 1'b1; addr = 32'h100;
      @(negedge clk);
      rr = 1'b0; lat = 0; busy_cnt = 0;
      while (!dv && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      chk("basic_latency", 32'(lat), 32'd4);
      chk("basic_busy_cycles", 32'(busy_cnt), 32'd4);
      chk("basic_busy_low_at_dv", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 8; k++) chk($sformatf("basic_line_%0d", k), ln[k], 32'hA0 + 32'(k));
      @(negedge clk);
      chk("dv_one_cycle", {31'd0, dv}, 32'd0);
      chk("line_hold", ln[3], 32'hA3);

      // offset-3 request: rotated with critical-word-first, aligned otherwise
      fetch0(32'h10C, lat);
      chk("off3_latency", 32'(lat), 32'd4);
      chk("off3_line0", ln[0], CWF ? 32'hA3 : 32'hA0);
      chk("off3_line4", ln[4], CWF ? 32'hA7 : 32'hA4);
      chk("off3_line5", ln[5], CWF ? 32'hA0 : 32'hA5);

      // requests at edge N+2 (busy) and N+4 (busy falling) are both dropped
      rr = 1'b1; addr = 32'h100; pulses = 0; pulse_c = 0; pulse_l0 = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         rr = (c == 2 || c == 4);
         if (c == 2) addr = 32'h120;
         if (dv) begin
            pulses++;
            pulse_c  = c;
            pulse_l0 = ln[0];
         end
         if (c == 6) chk("no_accept_on_busy_fall", {31'd0, busy}, 32'd0);
      end
      chk("busy_req_pulses", 32'(pulses), 32'd1);
      chk("busy_req_pulse_cycle", 32'(pulse_c), 32'd5);
      chk("busy_req_line0", pulse_l0, 32'hA0);
      fetch0(32'h120, lat);
      chk("after_busy_latency", 32'(lat), 32'd4);
      chk("after_busy_line0", ln[0], 32'hA8);

      // reset two edges into a fetch; a same-cycle load must lose to reset
      rr = 1'b1; addr = 32'h100; pulses = 0;
      @(negedge clk);
      rr = 1'b0;
      @(negedge clk);
      reset = 1'b1; load_en = 1'b1; load_addr = 32'h100; load_data = 32'hFFFF_FFFF;
      @(negedge clk);
      reset = 1'b0; load_en = 1'b0;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_dv", {31'd0, dv}, 32'd0);
      chk("rst_mid_line0", ln[0], 32'd0);
      for (int c = 0; c < 6; c++) begin
         if (dv) pulses++;
         @(negedge clk);
      end
      chk("rst_mid_no_pulse", 32'(pulses), 32'd0);
      fetch0(32'h100, lat);
      chk("after_rst_latency", 32'(lat), 32'd4);
      chk("after_rst_line0", ln[0], 32'hA0);

      // loads to the in-flight line during WAIT and on the RESP edge
      rr = 1'b1; addr = 32'h100;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rr      = 1'b0;
         load_en = (c == 1 || c == 4);
         load_addr = (c == 1) ? 32'h104 : 32'h108;
         load_data = (c == 1) ? 32'h0000_DEAD : 32'h0000_BEEF;
         if (c == 5) begin
            chk("load_dv", {31'd0, dv}, 32'd1);
            chk("load_wait_line1", ln[1], 32'h0000_DEAD);
            chk("load_resp_line2", ln[2], 32'h0000_BEEF);
            chk("load_line0", ln[0], 32'hA0);
         end
      end
      load_en = 1'b0;

      // LATENCY=1 instance, then wrapped address with a simultaneous load
      rr1 = 1'b1; addr1 = 32'h100;
      @(negedge clk);
      rr1 = 1'b0;
      chk("lat1_busy", {31'd0, busy1}, 32'd1);
      chk("lat1_dv_early", {31'd0, dv1}, 32'd0);
      @(negedge clk);
      chk("lat1_dv", {31'd0, dv1}, 32'd1);
      chk("lat1_line0", ln1[0], 32'hA0);
      chk("lat1_line1", ln1[1], 32'h0000_DEAD);
      @(negedge clk);
      rr1 = 1'b1; addr1 = 32'h100 + 32'(4 * DEPTH);
      load_en = 1'b1; load_addr = 32'h11C; load_data = 32'h0000_1234;
      @(negedge clk);
      rr1 = 1'b0; load_en = 1'b0;
      @(negedge clk);
      chk("wrap_dv", {31'd0, dv1}, 32'd1);
      chk("wrap_line0", ln1[0], 32'hA0);
      chk("wrap_line3", ln1[3], 32'hA3);
      chk("wrap_simul_load_line7", ln1[7], 32'h0000_1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_line_responder.md
IMEM_LINE_RESPONDER -- requirements
Module: imem_line_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to data_valid, legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array, power of 2, at least 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port read_request, input, 1 bit: line fetch request from the control unit on a cache miss.
REQ-006 SHALL have port addr, input, 32 bits: miss PC; addr[4:2] is the word offset and the upper bits select the line.
REQ-007 SHALL have port load_en, input, 1 bit: program-preload write strobe.
REQ-008 SHALL have port load_addr, input, 32 bits: byte address of the preload word.
REQ-009 SHALL have port load_data, input, 32 bits: preload word.
REQ-010 SHALL have port busy, output, 1 bit: high while a fetch is in flight.
REQ-011 SHALL have port data_valid, output, 1 bit: one-cycle pulse that drives the I-cache update input.
REQ-012 SHALL have ports line_0 to line_7, output, 32 bits each: words that drive update_cache_0 to update_cache_7.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 In IDLE, read_request=1 SHALL latch addr, set busy=1 on the next cycle, and go to RESP if LATENCY=1, otherwise to WAIT with counter=LATENCY-2.
REQ-015 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP when the counter equals 0.
REQ-016 In RESP, the block SHALL read 8 words, register them onto line_0..7, pulse data_valid for exactly 1 cycle, clear busy and return to IDLE.
REQ-017 For a request accepted at edge N, data_valid SHALL be high in the cycle after edge N+LATENCY.
REQ-018 While busy=1, read_request SHALL be ignored; there SHALL be no queueing, and the control unit re-requests.
REQ-019 A read_request in the same cycle that busy falls SHALL NOT be accepted; acceptance SHALL happen only in IDLE.
REQ-020 line_0..7 SHALL hold their value after data_valid falls, until the next response.
REQ-021 Word index SHALL be byte address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the array size.
REQ-022 When load_en=1, the block SHALL write load_data at load_addr on the clock edge, in any state.
REQ-023 On simultaneous load_en and read_request, both SHALL be accepted.
REQ-024 A load that targets the in-flight line at or before the RESP edge SHALL be visible in the response.

Reset
REQ-025 reset=1 SHALL force state IDLE, counter 0, busy 0, data_valid 0 and line_0..7 to 0.
REQ-026 Reset mid-fetch SHALL abort the fetch with no data_valid pulse.
REQ-027 Reset SHALL take priority over read_request and load_en in the same cycle.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With macro IMEM_CRIT_WORD_FIRST_EN defined, line_k SHALL equal mem[line_base + ((addr[4:2]+k) mod 8)], matching the cache's offset-relative fill.
REQ-030 With IMEM_CRIT_WORD_FIRST_EN undefined, line_k SHALL equal mem[line_base + k] (aligned order), and addr[4:2] SHALL be ignored.

Structure
REQ-031 Package rv_mem_pkg SHALL hold LINE_WORDS=8, WORD_W=32, OFFSET_W=3 and an enum for the FSM states.
REQ-032 Storage SHALL be one sub-module, imem_word_array, with 1 write port and an 8-word line read port.

Verification
REQ-033 Preload mem[0x40..0x47]=0xA0..0xA7, then read_request at addr 0x100 -> data_valid in cycle N+4, line_0..7=0xA0..0xA7, busy high for 4 cycles.
REQ-034 With CWF_EN defined, a request at addr 0x10C (offset 3) -> line_0=mem[0x43], line_4=mem[0x47], line_5=mem[0x40].
REQ-035 Second read_request while busy -> ignored, exactly one data_valid pulse; a request after busy=0 is accepted normally.
REQ-036 Assert reset 2 cycles after a request -> no data_valid, busy=0 and line_0..7=0 the next cycle; a new request is served after reset.
REQ-037 load_en to word 0x41 (data 0xDEAD) during WAIT of a fetch at 0x100 -> line_1=0xDEAD.
REQ-038 With LATENCY=1, request at 0x100 -> data_valid in the cycle after the next edge; with addr 0x100+4*DEPTH_WORDS -> same data (wrap).
